bp_nonsynth_host_io_arbiter: RTL
================================

Name: bp_nonsynth_host_io_arbiter

Overview:
- Shares the single I/O command/response port of the nonsynth host (bedrock mem msg, valid/ready-and command, valid/yumi response) among num_req_p requesters, e.g. per-core I/O channels or a debug injector.
- Round-robin arbitrates commands and records the source id of each issued command in an in-order tag queue.
- Steers each returning response to the requester whose tag is at the queue head; the host returns responses in command order.
- Sits directly in front of the host in the testbench.

Parameters:
- num_req_p, 4, number of requesters (2..16).
- msg_width_p, 128, width of one opaque mem message, header plus data.
- max_outstanding_p, 8, depth of the tag queue; maximum number of issued commands without a response (power of 2, >= 2).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- io_cmd_i  in  num_req_p*msg_width_p  requester commands, slice i = requester i.
- io_cmd_v_i  in  num_req_p  per-requester command valid.
- io_cmd_ready_and_o  out  num_req_p  per-requester command ready-and.
- io_cmd_o  out  msg_width_p  command to host.
- io_cmd_v_o  out  1  command valid to host.
- io_cmd_ready_and_i  in  1  host command ready-and.
- io_resp_i  in  msg_width_p  response from host.
- io_resp_v_i  in  1  host response valid.
- io_resp_yumi_o  out  1  response consumed.
- io_resp_o  out  num_req_p*msg_width_p  response broadcast; every slice equals io_resp_i.
- io_resp_v_o  out  num_req_p  per-requester response valid.
- io_resp_yumi_i  in  num_req_p  per-requester response yumi.
- outstanding_o  out  clog2(max_outstanding_p+1)  current tag queue occupancy.
- error_o  out  1  sticky error: a response arrived with the tag queue empty.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - Tag queue empty, outstanding_o=0, error_o=0.
  - Round-robin pointer=0.
  - All valid, ready and yumi outputs 0 while reset is held; outputs are combinational from reset-cleared state.
- Command arbitration (combinational, zero latency):
  - Grant goes to the first requester with io_cmd_v_i set, searching from rr_ptr upward and wrapping modulo num_req_p.
  - can_issue = ~full (occupancy < max_outstanding_p, sampled from registered state).
  - io_cmd_v_o = |io_cmd_v_i & can_issue.
  - io_cmd_o = io_cmd_i slice of the granted requester; '0 when no grant.
  - io_cmd_ready_and_o[i] = grant[i] & can_issue & io_cmd_ready_and_i. At most one bit is set.
- Command handshake (io_cmd_v_o & io_cmd_ready_and_i):
  - Push the granted id into the tag queue.
  - rr_ptr <= (granted id + 1) mod num_req_p.
  - Without a handshake, rr_ptr holds; the grant may change if valids change.
- Response steering:
  - io_resp_v_o[head_tag] = io_resp_v_i & ~empty; all other bits 0.
  - io_resp_yumi_o = io_resp_yumi_i[head_tag] & ~empty.
  - Yumi bits from non-head requesters are ignored.
  - Pop on io_resp_yumi_o.
- Spurious response (io_resp_v_i while empty):
  - io_resp_yumi_o=1 in the same cycle to drop the message.
  - error_o set and held until reset; no io_resp_v_o asserted.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When full, the pop completes but the push is blocked that cycle; there is no bypass because can_issue uses registered occupancy.
- Ordering:
  - A response is never delivered in the same cycle as its own command; the tag must already be registered.
  - The queue is strict FIFO. Read/write pointers wrap at max_outstanding_p.
  - Full and empty are resolved with an extra pointer bit or occupancy counter.
- Reset mid-operation: all in-flight tags are discarded; responses arriving after reset follow the spurious-response rule.
- outstanding_o = registered occupancy; it updates the cycle after each push or pop.

Test Plan:
- Reset: hold reset_n_i low with io_cmd_v_i=4'b1111 -> io_cmd_v_o=0, all ready=0, outstanding_o=0, error_o=0. Release -> first grant to requester 0.
- Fairness: all 4 requesters valid continuously, host always ready, responses held off -> issue order 0,1,2,3,0,1,2,3 and full after 8. Then io_cmd_v_o=0 and io_cmd_ready_and_o=0 until the first response pop.
- Steering: requester 2 issues cmd A, then requester 0 issues cmd B; host returns A then B -> io_resp_v_o=4'b0100 then 4'b0001. outstanding_o goes 1,2,1,0.
- Backpressure: io_cmd_ready_and_i=0 for 5 cycles with requesters 1 and 3 valid -> io_cmd_o stable at requester 1's message, rr_ptr unchanged, no push. On ready, requester 1 issues, then requester 3.
- Full with simultaneous pop: queue full; in one cycle the head response is yumi'd and requester 0 is valid -> pop occurs, no push, outstanding_o=7. Requester 0 issues next cycle.
- Spurious response and mid-op reset: 3 outstanding, pulse reset_n_i low -> outstanding_o=0 immediately. A subsequent io_resp_v_i -> io_resp_yumi_o=1, io_resp_v_o=0, error_o=1 and sticky.

Source files
------------

// File: rtl/bp_nonsynth_host_io_arbiter_if.sv
// Command/response bundle between the requesters, the host I/O port and the arbiter.
// Signal suffixes are from the arbiter's point of view; the arbiter takes the slave modport.
interface bp_nonsynth_host_io_arbiter_if #(
  parameter int unsigned num_req_p         = 4,
  parameter int unsigned msg_width_p       = 128,
  parameter int unsigned max_outstanding_p = 8
);
  localparam int unsigned cnt_w = $clog2(max_outstanding_p + 1);

  logic [num_req_p*msg_width_p-1:0] io_cmd_i;
  logic [num_req_p-1:0]             io_cmd_v_i;
  logic [num_req_p-1:0]             io_cmd_ready_and_o;
  logic [msg_width_p-1:0]           io_cmd_o;
  logic                             io_cmd_v_o;
  logic                             io_cmd_ready_and_i;
  logic [msg_width_p-1:0]           io_resp_i;
  logic                             io_resp_v_i;
  logic                             io_resp_yumi_o;
  logic [num_req_p*msg_width_p-1:0] io_resp_o;
  logic [num_req_p-1:0]             io_resp_v_o;
  logic [num_req_p-1:0]             io_resp_yumi_i;
  logic [cnt_w-1:0]                 outstanding_o;
  logic                             error_o;

  modport slave (
    input  io_cmd_i, io_cmd_v_i, io_cmd_ready_and_i, io_resp_i, io_resp_v_i, io_resp_yumi_i,
    output io_cmd_ready_and_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o, io_resp_o, io_resp_v_o,
           outstanding_o, error_o
  );

  modport master (
    output io_cmd_i, io_cmd_v_i, io_cmd_ready_and_i, io_resp_i, io_resp_v_i, io_resp_yumi_i,
    input  io_cmd_ready_and_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o, io_resp_o, io_resp_v_o,
           outstanding_o, error_o
  );
endinterface

// File: rtl/bp_nonsynth_host_io_arbiter.sv
// Round-robin sharing of the host I/O port among requesters; an in-order tag queue
// steers each in-order response back to the requester that issued its command.
module bp_nonsynth_host_io_arbiter #(
  parameter int unsigned num_req_p         = 4,
  parameter int unsigned msg_width_p       = 128,
  parameter int unsigned max_outstanding_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bp_nonsynth_host_io_arbiter_if.slave io
);

  localparam int unsigned id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int unsigned cnt_w = $clog2(max_outstanding_p + 1);

  logic [id_w-1:0]        rr_ptr_q, rr_ptr_d;
  logic [id_w-1:0]        tags_q [max_outstanding_p];
  logic [ptr_w-1:0]       wptr_q, rptr_q;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic                   error_q;

  logic                   empty, full, can_issue, any_v, push, pop;
  logic [id_w-1:0]        grant_id, head_tag;
  logic [msg_width_p-1:0] grant_cmd;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == cnt_w'(max_outstanding_p));
  assign can_issue = reset_n_i & ~full;
  assign head_tag  = tags_q[rptr_q];

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    any_v     = 1'b0;
    grant_id  = '0;
    grant_cmd = '0;
    idx       = 0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      idx = (int'(rr_ptr_q) + i) % int'(num_req_p);
      if (!any_v && io.io_cmd_v_i[idx]) begin
        any_v     = 1'b1;
        grant_id  = id_w'(idx);
        grant_cmd = io.io_cmd_i[idx*msg_width_p +: msg_width_p];
      end
    end
  end

  assign io.io_cmd_o   = grant_cmd;
  assign io.io_cmd_v_o = any_v & can_issue;
  assign push          = any_v & can_issue & io.io_cmd_ready_and_i;

  always_comb begin
    io.io_cmd_ready_and_o = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      io.io_cmd_ready_and_o[i] = any_v & (grant_id == id_w'(i)) & can_issue & io.io_cmd_ready_and_i;
    end
  end

  // Responses go to the head tag; with no tag outstanding they are swallowed.
  always_comb begin
    io.io_resp_v_o = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      io.io_resp_v_o[i] = reset_n_i & io.io_resp_v_i & ~empty & (head_tag == id_w'(i));
    end
  end

  assign pop               = reset_n_i & ~empty & io.io_resp_yumi_i[head_tag];
  assign io.io_resp_yumi_o = reset_n_i & (empty ? io.io_resp_v_i : io.io_resp_yumi_i[head_tag]);
  assign io.io_resp_o      = {num_req_p{io.io_resp_i}};
  assign io.outstanding_o  = cnt_q;
  assign io.error_o        = error_q;

  always_comb begin
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    if (push && !pop) cnt_d = cnt_q + cnt_w'(1);
    if (pop && !push) cnt_d = cnt_q - cnt_w'(1);
    if (push) rr_ptr_d = (grant_id == id_w'(num_req_p - 1)) ? '0 : grant_id + id_w'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      for (int i = 0; i < int'(max_outstanding_p); i++) tags_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        tags_q[wptr_q] <= grant_id;
        wptr_q         <= wptr_q + ptr_w'(1);
      end
      if (pop) rptr_q <= rptr_q + ptr_w'(1);
      if (io.io_resp_v_i && empty) error_q <= 1'b1;
    end
  end

endmodule
